// File: rtl/dma_int_presenter_pkg.sv
// Shared definitions for the DMA interrupt presenter: FSM encoding, status bit
// positions and helpers for slicing an interrupt FIFO entry {status, descNum}.
package dma_int_presenter_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StPop     = 2'd1,
      StLoad    = 2'd2,
      StPresent = 2'd3
   } pres_state_e;

   // Status field bit positions
   localparam int unsigned ST_DONE     = 0;
   localparam int unsigned ST_WR_ERR   = 1;
   localparam int unsigned ST_RD_ERR   = 2;
   localparam int unsigned ST_INV_DESC = 3;

   // Entry layout: descriptor number in the low bits, status above it
   localparam int unsigned DESC_LSB = 0;

   function automatic int unsigned desc_msb(input int unsigned desc_w);
      return desc_w - 1;
   endfunction

   function automatic int unsigned status_lsb(input int unsigned desc_w);
      return desc_w;
   endfunction

   function automatic int unsigned status_msb(input int unsigned desc_w,
                                              input int unsigned status_w);
      return desc_w + status_w - 1;
   endfunction

endpackage

// File: rtl/dma_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones, cleared only by reset.
module dma_sat_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             inc_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   // Next count: hold once all-ones is reached so the value never wraps
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {Width{1'b1}})) begin
         cnt_d = cnt_q + Width'(1);
      end
   end

   // Count register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/dma_int_presenter.sv
// Pops DMA interrupt events one at a time and holds each as the presented
// interrupt until software clears it. ECC-corrupt and fully masked entries are
// dropped without involving software.
module dma_int_presenter
   import dma_int_presenter_pkg::*;
#(
   parameter int unsigned NUM_DESC_WIDTH = 5,
   parameter int unsigned STATUS_WIDTH   = 4,
   parameter int unsigned DROP_CNT_WIDTH = 8
) (
   input  logic                                   clock,
   input  logic                                   resetn,
   input  logic                                   fifoEmpty,
   input  logic [NUM_DESC_WIDTH+STATUS_WIDTH-1:0] rdData,
   input  logic                                   fifoDbErr,
   output logic                                   rdEn,
   input  logic [STATUS_WIDTH-1:0]                intMask,
   input  logic                                   intClr,
   input  logic                                   eccErrClr,
   output logic                                   intValid,
   output logic [STATUS_WIDTH-1:0]                intStatus,
   output logic [NUM_DESC_WIDTH-1:0]              intDescNum,
   output logic                                   interrupt,
   output logic                                   eccDbErr,
   output logic [DROP_CNT_WIDTH-1:0]              dropCnt
);

   localparam int unsigned DescMsb   = desc_msb(NUM_DESC_WIDTH);
   localparam int unsigned StatusLsb = status_lsb(NUM_DESC_WIDTH);
   localparam int unsigned StatusMsb = status_msb(NUM_DESC_WIDTH, STATUS_WIDTH);

   pres_state_e                state_q, state_d;
   logic                       int_valid_q, int_valid_d;
   logic [STATUS_WIDTH-1:0]    int_status_q, int_status_d;
   logic [NUM_DESC_WIDTH-1:0]  int_desc_q, int_desc_d;
   logic                       irq_q, irq_d;
   logic                       ecc_q, ecc_d;
   logic                       ecc_set;
   logic                       drop_inc;
   logic                       rd_en;

   logic [STATUS_WIDTH-1:0]    entry_status;
   logic [NUM_DESC_WIDTH-1:0]  entry_desc;

   assign entry_status = rdData[StatusMsb:StatusLsb];
   assign entry_desc   = rdData[DescMsb:DESC_LSB];

   // FSM next state, entry capture/clear and drop decisions
   always_comb begin
      state_d      = state_q;
      int_valid_d  = int_valid_q;
      int_status_d = int_status_q;
      int_desc_d   = int_desc_q;
      irq_d        = irq_q;
      ecc_set      = 1'b0;
      drop_inc     = 1'b0;
      rd_en        = 1'b0;
      case (state_q)
         StIdle: begin
            if (!fifoEmpty) begin
               state_d = StPop;
            end
         end
         StPop: begin
            rd_en   = 1'b1;
            state_d = StLoad;
         end
         StLoad: begin
            state_d = StIdle;
            if (fifoDbErr) begin
               ecc_set  = 1'b1;
               drop_inc = 1'b1;
            end else if ((entry_status & intMask) == '0) begin
               // Nothing enabled would raise the IRQ, so software never sees it
               drop_inc = 1'b1;
            end else begin
               int_valid_d  = 1'b1;
               int_status_d = entry_status;
               int_desc_d   = entry_desc;
               irq_d        = 1'b1;
               state_d      = StPresent;
            end
         end
         StPresent: begin
            if (intClr) begin
               int_valid_d  = 1'b0;
               int_status_d = '0;
               int_desc_d   = '0;
               irq_d        = 1'b0;
               state_d      = fifoEmpty ? StIdle : StPop;
            end else begin
               irq_d = |(int_status_q & intMask);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Sticky ECC flag; a new error wins over a simultaneous clear
   always_comb begin
      ecc_d = ecc_set | (ecc_q & ~eccErrClr);
   end

   // State and presented-entry registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= StIdle;
         int_valid_q  <= 1'b0;
         int_status_q <= '0;
         int_desc_q   <= '0;
         irq_q        <= 1'b0;
         ecc_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         int_valid_q  <= int_valid_d;
         int_status_q <= int_status_d;
         int_desc_q   <= int_desc_d;
         irq_q        <= irq_d;
         ecc_q        <= ecc_d;
      end
   end

   dma_sat_counter #(
      .Width (DROP_CNT_WIDTH)
   ) u_drop_cnt (
      .clock   (clock),
      .resetn  (resetn),
      .inc_i   (drop_inc),
      .count_o (dropCnt)
   );

   assign rdEn       = rd_en;
   assign intValid   = int_valid_q;
   assign intStatus  = int_status_q;
   assign intDescNum = int_desc_q;
   assign interrupt  = irq_q;
   assign eccDbErr   = ecc_q;

endmodule

// File: tb/tb_dma_int_presenter.sv
// Bench for dma_int_presenter: a queue-based FIFO model feeds the DUT; directed
// steps cover latency, ordering, masking, ECC and saturation, and a randomized
// phase compares presented entries against a transaction-level expectation.
module tb_dma_int_presenter;
   import dma_int_presenter_pkg::*;

   localparam int unsigned NW = 5;
   localparam int unsigned SW = 4;
   localparam int unsigned DW = 8;

   typedef struct packed {
      logic [SW-1:0] st;
      logic [NW-1:0] d;
      logic          db;
   } ent_t;

   logic              clock = 1'b0;
   logic              resetn;
   logic              fifoEmpty;
   logic [NW+SW-1:0]  rdData;
   logic              fifoDbErr;
   logic              rdEn;
   logic [SW-1:0]     intMask;
   logic              intClr;
   logic              eccErrClr;
   logic              intValid;
   logic [SW-1:0]     intStatus;
   logic [NW-1:0]     intDescNum;
   logic              interrupt;
   logic              eccDbErr;
   logic [DW-1:0]     dropCnt;

   int   tests = 0;
   int   fails = 0;
   int   rd_cnt = 0;
   ent_t fq[$];
   ent_t pq[$];

   always #5 clock = ~clock;

   dma_int_presenter #(
      .NUM_DESC_WIDTH (NW),
      .STATUS_WIDTH   (SW),
      .DROP_CNT_WIDTH (DW)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .fifoEmpty  (fifoEmpty),
      .rdData     (rdData),
      .fifoDbErr  (fifoDbErr),
      .rdEn       (rdEn),
      .intMask    (intMask),
      .intClr     (intClr),
      .eccErrClr  (eccErrClr),
      .intValid   (intValid),
      .intStatus  (intStatus),
      .intDescNum (intDescNum),
      .interrupt  (interrupt),
      .eccDbErr   (eccDbErr),
      .dropCnt    (dropCnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: FIFO model pops on a sampled rdEn; data valid the following cycle
   task automatic step();
      logic rd_was;
      ent_t e;
      rd_was = rdEn;
      @(posedge clock);
      #1;
      fifoDbErr = 1'b0;
      if (rd_was) begin
         rd_cnt++;
         chk("pop_nonempty", 32'(fq.size() > 0), 32'd1);
         if (fq.size() > 0) begin
            e         = fq.pop_front();
            rdData    = {e.st, e.d};
            fifoDbErr = e.db;
         end
      end
      fifoEmpty = (fq.size() == 0);
   endtask

   task automatic push(input logic [SW-1:0] st, input logic [NW-1:0] d, input logic db);
      ent_t e;
      e.st = st;
      e.d  = d;
      e.db = db;
      fq.push_back(e);
      fifoEmpty = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (intValid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("wait_valid_timeout", 32'(n < 20), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(intValid), 32'd0);
      chk({tag, "_irq"}, 32'(interrupt), 32'd0);
      chk({tag, "_status"}, 32'(intStatus), 32'd0);
      chk({tag, "_desc"}, 32'(intDescNum), 32'd0);
      chk({tag, "_rden"}, 32'(rdEn), 32'd0);
      chk({tag, "_drop"}, 32'(dropCnt), 32'd0);
      chk({tag, "_ecc"}, 32'(eccDbErr), 32'd0);
   endtask

   initial begin
      int   n;
      int   r0;
      int   cyc;
      int   dly;
      int   exp_drop;
      logic exp_ecc;
      logic held;
      logic seen;
      ent_t cur;
      logic [SW-1:0] st;

      resetn    = 1'b0;
      fifoEmpty = 1'b1;
      rdData    = '0;
      fifoDbErr = 1'b0;
      intMask   = 4'hF;
      intClr    = 1'b0;
      eccErrClr = 1'b0;
      cur       = '0;
      repeat (2) @(posedge clock);
      #1;
      chk_all_zero("reset");
      resetn = 1'b1;
      step();

      // Single entry: pop one cycle after fifoEmpty falls, present three cycles after
      push(SW'(1 << ST_DONE), 5'd7, 1'b0);
      chk("t1_idle_rden", 32'(rdEn), 32'd0);
      step();
      chk("t1_rden", 32'(rdEn), 32'd1);
      step();
      chk("t1_rden_pulse", 32'(rdEn), 32'd0);
      chk("t1_load_valid", 32'(intValid), 32'd0);
      step();
      chk("t1_irq", 32'(interrupt), 32'd1);
      chk("t1_valid", 32'(intValid), 32'd1);
      chk("t1_desc", 32'(intDescNum), 32'd7);
      chk("t1_status", 32'(intStatus), 32'd1);
      step();
      chk("t1_hold_irq", 32'(interrupt), 32'd1);
      chk("t1_hold_rden", 32'(rdEn), 32'd0);
      intClr = 1'b1;
      step();
      intClr = 1'b0;
      chk("t1_clr_irq", 32'(interrupt), 32'd0);
      chk("t1_clr_valid", 32'(intValid), 32'd0);
      chk("t1_clr_desc", 32'(intDescNum), 32'd0);
      chk("t1_clr_status", 32'(intStatus), 32'd0);
      step();
      chk("t1_idle_after", 32'(rdEn), 32'd0);

      // Back-to-back: in order, two cycles after each clear, one pop each
      r0 = rd_cnt;
      for (int k = 1; k <= 3; k++) push(SW'(1), NW'(k), 1'b0);
      for (int k = 1; k <= 3; k++) begin
         wait_valid(n);
         chk("t2_latency", 32'(n), (k == 1) ? 32'd3 : 32'd2);
         chk("t2_desc", 32'(intDescNum), 32'(k));
         intClr = 1'b1;
         step();
         intClr = 1'b0;
      end
      repeat (4) step();
      chk("t2_pops", 32'(rd_cnt - r0), 32'd3);
      chk("t2_end_valid", 32'(intValid), 32'd0);

      // Masked discard
      intMask = 4'b0001;
      r0      = rd_cnt;
      seen    = 1'b0;
      push(SW'(1 << ST_RD_ERR), 5'd5, 1'b0);
      repeat (6) begin
         step();
         if (intValid) seen = 1'b1;
      end
      chk("t3_never_valid", 32'(seen), 32'd0);
      chk("t3_pops", 32'(rd_cnt - r0), 32'd1);
      chk("t3_drop", 32'(dropCnt), 32'd1);
      chk("t3_idle", 32'(rdEn), 32'd0);
      chk("t3_ecc", 32'(eccDbErr), 32'd0);

      // ECC double-bit error, clear, and set-wins-over-clear
      intMask = 4'hF;
      push(SW'(1), 5'd9, 1'b1);
      repeat (5) step();
      chk("t4_ecc_set", 32'(eccDbErr), 32'd1);
      chk("t4_drop", 32'(dropCnt), 32'd2);
      chk("t4_valid", 32'(intValid), 32'd0);
      eccErrClr = 1'b1;
      step();
      eccErrClr = 1'b0;
      chk("t4_ecc_clr", 32'(eccDbErr), 32'd0);
      push(SW'(1), 5'd9, 1'b1);
      step();
      step();
      eccErrClr = 1'b1;
      step();
      eccErrClr = 1'b0;
      chk("t4_set_wins", 32'(eccDbErr), 32'd1);
      chk("t4_drop2", 32'(dropCnt), 32'd3);

      // Mask change while presenting
      push(SW'(1 << ST_WR_ERR), 5'd4, 1'b0);
      wait_valid(n);
      chk("t5_irq", 32'(interrupt), 32'd1);
      intMask = 4'h0;
      chk("t5_irq_registered", 32'(interrupt), 32'd1);
      step();
      chk("t5_irq_masked", 32'(interrupt), 32'd0);
      chk("t5_valid_kept", 32'(intValid), 32'd1);
      chk("t5_status", 32'(intStatus), 32'd2);
      intMask = 4'hF;
      step();
      chk("t5_irq_restored", 32'(interrupt), 32'd1);
      intClr = 1'b1;
      step();
      intClr = 1'b0;
      step();

      // Randomized batches against a transaction-level expectation
      exp_drop = 3;
      for (int b = 0; b < 8; b++) begin
         intMask   = SW'($urandom_range(1, 15));
         eccErrClr = 1'b1;
         step();
         eccErrClr = 1'b0;
         exp_ecc   = 1'b0;
         n = $urandom_range(3, 8);
         for (int i = 0; i < n; i++) begin
            ent_t e;
            e.st = SW'($urandom_range(0, 15));
            e.d  = NW'($urandom);
            e.db = ($urandom_range(0, 7) == 0);
            push(e.st, e.d, e.db);
            if (e.db) begin
               exp_ecc  = 1'b1;
               exp_drop = exp_drop + 1;
            end else if ((e.st & intMask) == '0) begin
               exp_drop = exp_drop + 1;
            end else begin
               pq.push_back(e);
            end
         end
         if (exp_drop > 255) exp_drop = 255;
         held = 1'b0;
         dly  = 0;
         cyc  = 0;
         while ((fq.size() != 0 || pq.size() != 0 || held) && cyc < 400) begin
            if (intValid && !held) begin
               if (pq.size() == 0) begin
                  chk("rnd_unexpected", 32'(intValid), 32'd0);
               end else begin
                  cur  = pq.pop_front();
                  held = 1'b1;
                  dly  = $urandom_range(0, 2);
               end
            end
            if (held) begin
               chk("rnd_desc", 32'(intDescNum), 32'(cur.d));
               chk("rnd_status", 32'(intStatus), 32'(cur.st));
               chk("rnd_irq", 32'(interrupt), 32'(|(cur.st & intMask)));
            end
            chk("rnd_no_pop_while_held", 32'(rdEn & intValid), 32'd0);
            if (held && dly == 0) begin
               intClr = 1'b1;
               step();
               intClr = 1'b0;
               held   = 1'b0;
               chk("rnd_clr_valid", 32'(intValid), 32'd0);
               chk("rnd_clr_irq", 32'(interrupt), 32'd0);
            end else begin
               if (held) dly--;
               step();
            end
            cyc++;
         end
         chk("rnd_timeout", 32'(cyc < 400), 32'd1);
         repeat (3) step();
         chk("rnd_drop", 32'(dropCnt), 32'(exp_drop));
         chk("rnd_ecc", 32'(eccDbErr), 32'(exp_ecc));
         chk("rnd_valid_end", 32'(intValid), 32'd0);
      end

      // Reset while presenting clears everything asynchronously
      intMask = 4'hF;
      push(SW'(1), 5'd3, 1'b0);
      wait_valid(n);
      #2;
      resetn = 1'b0;
      #1;
      chk_all_zero("t6_async");
      fq.delete();
      fifoEmpty = 1'b1;
      step();
      resetn = 1'b1;
      step();
      chk("t6_idle", 32'(rdEn), 32'd0);

      // Saturation: 260 masked entries, counter stops at all-ones
      intMask = 4'b0001;
      r0      = rd_cnt;
      for (int i = 0; i < 260; i++) begin
         st = SW'(1 << ST_INV_DESC);
         push(st, NW'(i), 1'b0);
      end
      cyc = 0;
      while (fq.size() != 0 && cyc < 2000) begin
         step();
         cyc++;
      end
      chk("t7_timeout", 32'(cyc < 2000), 32'd1);
      repeat (4) step();
      chk("t7_pops", 32'(rd_cnt - r0), 32'd260);
      chk("t7_sat", 32'(dropCnt), 32'd255);
      chk("t7_valid", 32'(intValid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dma_int_presenter.md
Name: dma_int_presenter

Overview:
- Consumes the DMA interrupt-event FIFO. Pops one entry at a time and presents it as the current interrupt status, descriptor number and IRQ line.
- Holds each entry until software clears it through the register block, then fetches the next entry.
- Sits between the interrupt-event FIFO (upstream) and the AXI4-Lite register file / top-level IRQ output (downstream).

Parameters:
- NUM_DESC_WIDTH, 5, width of the descriptor-number field of a FIFO entry.
- STATUS_WIDTH, 4, width of the status field. Bit 0 op-complete, bit 1 write-error, bit 2 read-error, bit 3 invalid-descriptor.
- DROP_CNT_WIDTH, 8, width of the saturating discarded-entry counter.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- fifoEmpty  in  1  interrupt FIFO empty flag.
- rdData  in  NUM_DESC_WIDTH+STATUS_WIDTH  FIFO read data {status, descNum}, valid the cycle after rdEn.
- fifoDbErr  in  1  FIFO ECC double-bit detect, qualifies rdData.
- rdEn  out  1  FIFO pop, single-cycle pulse.
- intMask  in  STATUS_WIDTH  per-status-bit interrupt enable.
- intClr  in  1  single-cycle software clear of the presented entry.
- eccErrClr  in  1  clears eccDbErr.
- intValid  out  1  an entry is being presented.
- intStatus  out  STATUS_WIDTH  status of the presented entry.
- intDescNum  out  NUM_DESC_WIDTH  descriptor number of the presented entry.
- interrupt  out  1  IRQ line, registered.
- eccDbErr  out  1  sticky ECC double-bit error.
- dropCnt  out  DROP_CNT_WIDTH  saturating count of auto-discarded entries.

Behaviour:
- Reset: asynchronous on resetn low.
  - All outputs reset to 0; state = IDLE.
  - Reset mid-operation abandons the held entry. The FIFO itself is reset by the same resetn.
- FSM states: IDLE, POP, LOAD, PRESENT.
- IDLE:
  - If !fifoEmpty, go to POP next edge.
  - Otherwise stay; intClr is ignored.
- POP:
  - rdEn=1 for exactly this cycle.
  - Always go to LOAD.
- LOAD:
  - rdData is valid this cycle and is sampled at the end edge.
  - If fifoDbErr=1: discard the entry, set eccDbErr, increment dropCnt, go to IDLE.
  - Else if (status & intMask)==0: discard the entry, increment dropCnt, go to IDLE. Masked entries need no software clear.
  - Else: load intStatus and intDescNum; set intValid=1 and interrupt=1; go to PRESENT.
- PRESENT:
  - Each cycle, interrupt is registered as |(intStatus & intMask). A mask change takes effect one cycle later; intValid stays 1.
  - On intClr: intValid, interrupt, intStatus and intDescNum go to 0 at the next edge.
  - After intClr, go to POP if !fifoEmpty, else IDLE.
  - intClr outside PRESENT has no effect.
- Latency: fifoEmpty falling at edge N puts rdEn high in cycle N+1→N+2, and interrupt is high from edge N+3.
- Throughput: back-to-back entries are presented 2 cycles after intClr (POP, LOAD).
- rdEn is never asserted when fifoEmpty=1 at the sampling edge. The block never pops a second entry while one is held.
- dropCnt saturates at all-ones and does not wrap. It is cleared only by reset.
- eccDbErr:
  - Sticky until eccErrClr.
  - If eccErrClr and a new DB error occur in the same cycle, set wins.
- Only fifoDbErr is acted upon; FIFO single-bit-corrected data is used as is.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, POP=2'd1, LOAD=2'd2, PRESENT=2'd3).
  - Status bit index constants (ST_DONE=0, ST_WR_ERR=1, ST_RD_ERR=2, ST_INV_DESC=3).
  - Entry field slicing constants derived from NUM_DESC_WIDTH and STATUS_WIDTH.
- One sub-module: dma_sat_counter (parameterised saturating incrementer) for dropCnt.
- Everything else stays in a single module.

Test Plan:
- Single entry: push {status=4'b0001, desc=5'd7}, intMask=4'hF -> rdEn 1 cycle after fifoEmpty falls. interrupt=1, intDescNum=7, intStatus=1 three cycles after fifoEmpty falls. After intClr, interrupt=0 next cycle.
- Back-to-back: three entries desc 1,2,3 queued, intClr issued each time intValid rises -> presented in order 1,2,3. Each is presented 2 cycles after the prior intClr; no extra rdEn pulses.
- Masked discard: intMask=4'b0001, entry status=4'b0100 -> entry is popped, intValid never rises, dropCnt=1, state returns to IDLE.
- ECC: fifoDbErr=1 during LOAD -> entry is discarded, eccDbErr=1 and dropCnt increments. eccErrClr pulse -> eccDbErr=0. Simultaneous clear and new error -> eccDbErr stays 1.
- Mask change while presenting: entry status=4'b0010 presented, then intMask changes 4'hF->4'h0 -> interrupt=0 one cycle later, intValid stays 1. Mask restored -> interrupt=1.
- Reset mid-PRESENT and saturation: assert resetn low while presenting -> all outputs 0 immediately. Then 260 masked entries -> dropCnt stops at 255.
